keypad_entry: RTL and testbench
===============================

Name: keypad_entry

Overview:
- Input-side counterpart of the 7-segment display multiplexer.
- Scans a 4x4 matrix keypad by driving one row at a time and reading the columns, then debounces the key.
- Assembles up to 4 BCD digits, converts them sequentially to binary, and presents a preset value plus a one-cycle load strobe to the 0000-9999 counter.
- entry_bcd can be routed to seg7_control so the digits show while they are typed.

Parameters:
- CLK_HZ, 50000000, input clock frequency.
- SCAN_HZ, 1000, row dwell rate. Dwell = CLK_HZ/SCAN_HZ cycles per row.
- DEBOUNCE_FRAMES, 4, consecutive identical 4-row frames required for a stable key.
- REPEAT_DELAY, 128, frames held before the first auto-repeat (KEYPAD_REPEAT_EN only).
- REPEAT_RATE, 32, frames between auto-repeats (KEYPAD_REPEAT_EN only).

Ports:
- clk_50MHz  input  1  single system clock.
- reset_button  input  1  asynchronous, active-low reset.
- col  input  4  keypad columns, active-low, externally pulled up, asynchronous; 2-flop synchronised internally.
- row  output  4  keypad rows, active-low, exactly one row low at any time.
- key_code  output  4  code of the last accepted key.
- key_valid  output  1  one-cycle pulse per accepted key.
- entry_bcd  output  16  digits entered so far; newest digit in [3:0].
- digit_cnt  output  3  number of digits entered, 0..4.
- load_value  output  16  binary preset value, 0..9999; bits [15:14] are always 0.
- load_valid  output  1  one-cycle pulse; load_value is valid in the same cycle.

Behaviour:
- Reset (async assert, sync release): row=4'b1110, row_idx=0, key_code=0, key_valid=0, entry_bcd=0, digit_cnt=0, load_value=0, load_valid=0, FSM=IDLE, debounce state=released.
- Scan:
  - row_idx advances 0->1->2->3->0 every dwell period; row = ~(1<<row_idx).
  - Synchronised col is sampled on the last cycle of each dwell.
  - One frame is complete after the row-3 sample.
- Key map (row,col):
  - row 0: 1 2 3 A
  - row 1: 4 5 6 B
  - row 2: 7 8 9 C
  - row 3: * 0 # D
  - Codes: digits 0-9 map to 0x0-0x9; A=0xA, B=0xB, C=0xC, *=0xE, #=0xF, D=0xD.
- Frame result:
  - Exactly one closed contact gives the candidate code.
  - Zero contacts gives NONE.
  - Two or more contacts also give NONE (ghosting rejection).
- Debounce:
  - The candidate must be identical for DEBOUNCE_FRAMES consecutive frames to become stable.
  - A stable transition from NONE to K pulses key_valid for 1 cycle with key_code=K.
  - Stable K to a different stable key J must pass through stable NONE first; no pulse is emitted for J until it does.
  - Holding a key produces no further pulses, except with KEYPAD_REPEAT_EN.
- Entry FSM, states IDLE (digit_cnt=0), ENTRY, CONVERT:
  - Digit key with digit_cnt<4: entry_bcd={entry_bcd[11:0],d}, digit_cnt+1, state=ENTRY.
  - Digit key with digit_cnt=4: ignored; entry_bcd is unchanged.
  - B (backspace): entry_bcd>>=4, digit_cnt-1. With digit_cnt=0 it is a no-op. Reaching 0 returns to IDLE.
  - C (clear): entry_bcd=0, digit_cnt=0, state=IDLE.
  - A (enter) in IDLE: ignored; no load_valid.
  - A (enter) in ENTRY: go to CONVERT.
  - D, *, #: produce key_valid but have no effect on entry.
  - Any key_valid arriving in CONVERT is dropped by the FSM; key_valid still pulses.
- CONVERT:
  - acc=0, then 4 cycles, most-significant nibble first: acc = (acc<<3)+(acc<<1)+nibble.
  - Cycle 5: load_value=acc, load_valid=1, entry_bcd=0, digit_cnt=0, state=IDLE.
  - Leading zero nibbles (fewer than 4 digits entered) are harmless.
  - Latency: enter key_valid at cycle T gives load_valid at T+5.
- load_value holds its value until the next conversion completes.
- Reset mid-CONVERT aborts the conversion: no load_valid, and load_value returns to 0.

Optional Feature:
- Macro KEYPAD_REPEAT_EN.
- Defined: while a digit key or B is held stable, key_valid re-pulses after REPEAT_DELAY frames, then every REPEAT_RATE frames, until release. Each re-pulse is processed by the FSM as a normal key press.
- Not defined: exactly one key_valid per press; the repeat counters are not synthesised.

Test Plan (sim uses CLK_HZ=1000, SCAN_HZ=100, so dwell = 10 cycles):
- Reset released, no keys -> row cycles 1110,1101,1011,0111 every 10 cycles; key_valid, load_valid and entry_bcd stay 0.
- Press 4,2,0,7 then A, each held 6 frames with 6 frames released between -> entry_bcd=0x4207, digit_cnt=4; load_valid exactly 5 cycles after A's key_valid with load_value=4207 (0x106F); entry then clears.
- Press 9,9,9,9,5 then A -> 5th digit ignored; load_value=9999 (0x270F).
- Press 1,2,B,3,A -> entry_bcd reads 0x0001, 0x0012, 0x0001, then 0x0013; load_value=13. A in IDLE alone -> no load_valid.
- Contact bounce toggling every frame for 3 frames, then solid '5' -> exactly one key_valid with key_code=5. Keys 1 and 5 held together -> no key_valid.
- Assert reset_button low during CONVERT -> outputs return to reset values immediately; no load_valid follows.

Source files
------------

// File: rtl/keypad_entry.sv
// keypad_entry: 4x4 matrix keypad scanner with frame debounce, BCD digit
// entry and sequential BCD-to-binary conversion feeding a counter preset.
// Optional auto-repeat on held digit/backspace keys: define KEYPAD_REPEAT_EN.
module keypad_entry #(
   parameter int CLK_HZ          = 50000000,
   parameter int SCAN_HZ         = 1000,
   parameter int DEBOUNCE_FRAMES = 4,
   parameter int REPEAT_DELAY    = 128,
   parameter int REPEAT_RATE     = 32
) (
   input  logic        clk_50MHz,
   input  logic        reset_button,
   input  logic [3:0]  col,
   output logic [3:0]  row,
   output logic [3:0]  key_code,
   output logic        key_valid,
   output logic [15:0] entry_bcd,
   output logic [2:0]  digit_cnt,
   output logic [15:0] load_value,
   output logic        load_valid
);

   localparam int DWELL = CLK_HZ / SCAN_HZ;
   localparam int DW    = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam int DBW   = $clog2(DEBOUNCE_FRAMES + 1);
   // Frame candidate: bit 4 set means no single key (none or ghosted).
   localparam logic [4:0] NONE = 5'h10;

   typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_CONVERT} state_t;

   logic [3:0]     col_meta_q, col_sync_q;
   logic [DW-1:0]  div_q;
   logic [1:0]     row_idx_q;
   logic           sample, frame_end;
   logic [1:0]     hits_q, hits_d, hits_base;
   logic [3:0]     code_q, code_d, code_this;
   logic [2:0]     n_this, hits_sum;
   logic [3:0]     closed;
   logic [4:0]     cand;
   logic [4:0]     last_q, last_d, stable_q, stable_d;
   logic [DBW-1:0] same_q, same_d;
   logic           press;
   logic           rpt_fire;
   logic           key_valid_q, key_valid_d;
   logic [3:0]     key_code_q, key_code_d;
   state_t         state_q;
   logic [15:0]    entry_q;
   logic [2:0]     cnt_q;
   logic [13:0]    acc_q, acc_step;
   logic [1:0]     idx_q;
   logic [3:0]     conv_nib;
   logic [15:0]    load_value_q;
   logic           load_valid_q;

   function automatic logic [3:0] key_map(input logic [3:0] rc);
      logic [3:0] k;
      case (rc)
         4'd0:  k = 4'h1;  4'd1:  k = 4'h2;  4'd2:  k = 4'h3;  4'd3:  k = 4'hA;
         4'd4:  k = 4'h4;  4'd5:  k = 4'h5;  4'd6:  k = 4'h6;  4'd7:  k = 4'hB;
         4'd8:  k = 4'h7;  4'd9:  k = 4'h8;  4'd10: k = 4'h9;  4'd11: k = 4'hC;
         4'd12: k = 4'hE;  4'd13: k = 4'h0;  4'd14: k = 4'hF;  default: k = 4'hD;
      endcase
      return k;
   endfunction

   // Two-flop synchroniser for the asynchronous column inputs
   always_ff @(posedge clk_50MHz or negedge reset_button) begin
      if (!reset_button) begin
         col_meta_q <= '1;
         col_sync_q <= '1;
      end else begin
         col_meta_q <= col;
         col_sync_q <= col_meta_q;
      end
   end

   assign sample    = (div_q == DW'(DWELL - 1));
   assign frame_end = sample && (row_idx_q == 2'd3);
   assign row       = ~(4'b0001 << row_idx_q);
   assign closed    = ~col_sync_q;

   // Row dwell timer and row index
   always_ff @(posedge clk_50MHz or negedge reset_button) begin
      if (!reset_button) begin
         div_q     <= '0;
         row_idx_q <= '0;
      end else if (sample) begin
         div_q     <= '0;
         row_idx_q <= row_idx_q + 2'd1;
      end else begin
         div_q <= div_q + 1'b1;
      end
   end

   // Count closed contacts in this row sample and fold into the frame tally
   always_comb begin
      n_this    = '0;
      code_this = '0;
      for (int unsigned c = 0; c < 4; c++) begin
         n_this = n_this + {2'b00, closed[c]};
         if (closed[c]) code_this = key_map({row_idx_q, c[1:0]});
      end
      hits_base = (row_idx_q == 2'd0) ? 2'd0 : hits_q;
      hits_sum  = {1'b0, hits_base} + n_this;
      hits_d    = (hits_sum > 3'd2) ? 2'd2 : hits_sum[1:0];
      code_d    = (n_this == 3'd1 && hits_base == 2'd0) ? code_this : code_q;
      cand      = (hits_sum == 3'd1) ? {1'b0, code_d} : NONE;
   end

   // Frame accumulator registers, updated on each row sample
   always_ff @(posedge clk_50MHz or negedge reset_button) begin
      if (!reset_button) begin
         hits_q <= '0;
         code_q <= '0;
      end else if (sample) begin
         hits_q <= hits_d;
         code_q <= code_d;
      end
   end

   // Debounce: a key only becomes stable from the released state, so a
   // direct K->J change is held at K until a stable release is seen.
   always_comb begin
      same_d   = same_q;
      last_d   = last_q;
      stable_d = stable_q;
      press    = 1'b0;
      if (frame_end) begin
         if (cand == last_q) begin
            if (same_q < DBW'(DEBOUNCE_FRAMES)) same_d = same_q + 1'b1;
         end else begin
            last_d = cand;
            same_d = DBW'(1);
         end
         if (same_d == DBW'(DEBOUNCE_FRAMES)) begin
            if (cand == NONE) begin
               stable_d = NONE;
            end else if (stable_q == NONE) begin
               stable_d = cand;
               press    = 1'b1;
            end
         end
      end
   end

`ifdef KEYPAD_REPEAT_EN
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RW      = $clog2(RPT_MAX + 1);

   logic [RW-1:0] rpt_cnt_q, rpt_cnt_d, rpt_limit;
   logic          rpt_fast_q, rpt_fast_d;

   // Auto-repeat frame counting while a digit or backspace stays held
   always_comb begin
      rpt_cnt_d  = rpt_cnt_q;
      rpt_fast_d = rpt_fast_q;
      rpt_fire   = 1'b0;
      rpt_limit  = rpt_fast_q ? RW'(REPEAT_RATE) : RW'(REPEAT_DELAY);
      if (frame_end) begin
         if (stable_q != NONE && cand == stable_q &&
             (stable_q[3:0] <= 4'h9 || stable_q[3:0] == 4'hB)) begin
            if ((rpt_cnt_q + 1'b1) == rpt_limit) begin
               rpt_cnt_d  = '0;
               rpt_fast_d = 1'b1;
               rpt_fire   = 1'b1;
            end else begin
               rpt_cnt_d = rpt_cnt_q + 1'b1;
            end
         end else begin
            rpt_cnt_d  = '0;
            rpt_fast_d = 1'b0;
         end
      end
   end

   // Auto-repeat state registers
   always_ff @(posedge clk_50MHz or negedge reset_button) begin
      if (!reset_button) begin
         rpt_cnt_q  <= '0;
         rpt_fast_q <= 1'b0;
      end else begin
         rpt_cnt_q  <= rpt_cnt_d;
         rpt_fast_q <= rpt_fast_d;
      end
   end
`else
   assign rpt_fire = 1'b0;
`endif

   assign key_valid_d = press | rpt_fire;
   assign key_code_d  = press ? cand[3:0] : (rpt_fire ? stable_q[3:0] : key_code_q);

   // Debounce state and registered key outputs
   always_ff @(posedge clk_50MHz or negedge reset_button) begin
      if (!reset_button) begin
         same_q      <= '0;
         last_q      <= NONE;
         stable_q    <= NONE;
         key_valid_q <= 1'b0;
         key_code_q  <= '0;
      end else begin
         same_q      <= same_d;
         last_q      <= last_d;
         stable_q    <= stable_d;
         key_valid_q <= key_valid_d;
         key_code_q  <= key_code_d;
      end
   end

   // Conversion datapath: acc*10 + next nibble, most significant first
   always_comb begin
      case (idx_q)
         2'd0:    conv_nib = entry_q[15:12];
         2'd1:    conv_nib = entry_q[11:8];
         2'd2:    conv_nib = entry_q[7:4];
         default: conv_nib = entry_q[3:0];
      endcase
      acc_step = (acc_q << 3) + (acc_q << 1) + {10'b0, conv_nib};
   end

   // Entry FSM: digit assembly, edit keys, and sequential conversion
   always_ff @(posedge clk_50MHz or negedge reset_button) begin
      if (!reset_button) begin
         state_q      <= S_IDLE;
         entry_q      <= '0;
         cnt_q        <= '0;
         acc_q        <= '0;
         idx_q        <= '0;
         load_value_q <= '0;
         load_valid_q <= 1'b0;
      end else begin
         load_valid_q <= 1'b0;
         case (state_q)
            S_IDLE, S_ENTRY: begin
               if (key_valid_q) begin
                  if (key_code_q <= 4'h9) begin
                     if (cnt_q != 3'd4) begin
                        entry_q <= {entry_q[11:0], key_code_q};
                        cnt_q   <= cnt_q + 3'd1;
                        state_q <= S_ENTRY;
                     end
                  end else if (key_code_q == 4'hB) begin
                     if (cnt_q != 3'd0) begin
                        entry_q <= entry_q >> 4;
                        cnt_q   <= cnt_q - 3'd1;
                        if (cnt_q == 3'd1) state_q <= S_IDLE;
                     end
                  end else if (key_code_q == 4'hC) begin
                     entry_q <= '0;
                     cnt_q   <= '0;
                     state_q <= S_IDLE;
                  end else if (key_code_q == 4'hA && state_q == S_ENTRY) begin
                     acc_q   <= '0;
                     idx_q   <= '0;
                     state_q <= S_CONVERT;
                  end
               end
            end
            S_CONVERT: begin
               // The fourth accumulate step also publishes the result so the
               // strobe lands five cycles after the enter key pulse.
               acc_q <= acc_step;
               idx_q <= idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  load_value_q <= {2'b00, acc_step};
                  load_valid_q <= 1'b1;
                  entry_q      <= '0;
                  cnt_q        <= '0;
                  state_q      <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign key_code   = key_code_q;
   assign key_valid  = key_valid_q;
   assign entry_bcd  = entry_q;
   assign digit_cnt  = cnt_q;
   assign load_value = load_value_q;
   assign load_valid = load_valid_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Testbench for keypad_entry: table of key presses with expected entry and
// load results, plus hand-written scan, bounce, ghost and reset sequences.
module tb_keypad_entry;

   localparam int FRAME = 40;   // 4 rows x 10-cycle dwell
   localparam int HOLD  = 6;
   localparam int REL   = 6;

   logic        clk = 1'b0;
   logic        reset_button;
   logic [3:0]  col;
   logic [3:0]  row;
   logic [3:0]  key_code;
   logic        key_valid;
   logic [15:0] entry_bcd;
   logic [2:0]  digit_cnt;
   logic [15:0] load_value;
   logic        load_valid;

   logic [15:0] pressed = '0;

   int n_vec = 0;
   int n_bad = 0;
   int cyc = 0;
   int kv_cnt = 0, kv_cyc = 0, lv_cnt = 0, lv_lat = 0;
   logic [3:0]  kv_code = '0;
   logic [15:0] lv_val = '0;

   typedef struct {
      logic [3:0]  key;
      logic [15:0] exp_bcd;
      logic [2:0]  exp_cnt;
      logic        exp_load;
      logic [15:0] exp_val;
   } vec_t;

   vec_t vecs[28];

   keypad_entry #(
      .CLK_HZ(1000), .SCAN_HZ(100), .DEBOUNCE_FRAMES(4),
      .REPEAT_DELAY(128), .REPEAT_RATE(32)
   ) dut (
      .clk_50MHz(clk), .reset_button(reset_button), .col(col), .row(row),
      .key_code(key_code), .key_valid(key_valid), .entry_bcd(entry_bcd),
      .digit_cnt(digit_cnt), .load_value(load_value), .load_valid(load_valid)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Keypad matrix model: a pressed key pulls its column low when its row is driven low
   always_comb begin
      col = 4'hF;
      for (int unsigned r = 0; r < 4; r++)
         for (int unsigned c = 0; c < 4; c++)
            if (pressed[r*4+c] && !row[r]) col[c] = 1'b0;
   end

   // Event recorder for the strobes
   always @(negedge clk) begin
      if (key_valid) begin
         kv_cnt  <= kv_cnt + 1;
         kv_code <= key_code;
         kv_cyc  <= cyc;
      end
      if (load_valid) begin
         lv_cnt <= lv_cnt + 1;
         lv_val <= load_value;
         lv_lat <= cyc - kv_cyc;
      end
   end

   function automatic int key_index(input logic [3:0] code);
      case (code)
         4'h1: return 0;  4'h2: return 1;  4'h3: return 2;  4'hA: return 3;
         4'h4: return 4;  4'h5: return 5;  4'h6: return 6;  4'hB: return 7;
         4'h7: return 8;  4'h8: return 9;  4'h9: return 10; 4'hC: return 11;
         4'hE: return 12; 4'h0: return 13; 4'hF: return 14; default: return 15;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic press(input logic [3:0] code, input int hold_frames);
      @(negedge clk);
      pressed = '0;
      pressed[key_index(code)] = 1'b1;
      repeat (hold_frames * FRAME) @(negedge clk);
      pressed = '0;
      repeat (REL * FRAME) @(negedge clk);
      #1;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int kv0, lv0, guard;
      logic [3:0] rowtab [4];
      vecs[0]  = '{4'h4, 16'h0004, 3'd1, 1'b0, 16'h0000};
      vecs[1]  = '{4'h2, 16'h0042, 3'd2, 1'b0, 16'h0000};
      vecs[2]  = '{4'h0, 16'h0420, 3'd3, 1'b0, 16'h0000};
      vecs[3]  = '{4'h7, 16'h4207, 3'd4, 1'b0, 16'h0000};
      vecs[4]  = '{4'hA, 16'h0000, 3'd0, 1'b1, 16'h106F};
      vecs[5]  = '{4'h9, 16'h0009, 3'd1, 1'b0, 16'h0000};
      vecs[6]  = '{4'h9, 16'h0099, 3'd2, 1'b0, 16'h0000};
      vecs[7]  = '{4'h9, 16'h0999, 3'd3, 1'b0, 16'h0000};
      vecs[8]  = '{4'h9, 16'h9999, 3'd4, 1'b0, 16'h0000};
      vecs[9]  = '{4'h5, 16'h9999, 3'd4, 1'b0, 16'h0000};
      vecs[10] = '{4'hA, 16'h0000, 3'd0, 1'b1, 16'h270F};
      vecs[11] = '{4'h1, 16'h0001, 3'd1, 1'b0, 16'h0000};
      vecs[12] = '{4'h2, 16'h0012, 3'd2, 1'b0, 16'h0000};
      vecs[13] = '{4'hB, 16'h0001, 3'd1, 1'b0, 16'h0000};
      vecs[14] = '{4'h3, 16'h0013, 3'd2, 1'b0, 16'h0000};
      vecs[15] = '{4'hA, 16'h0000, 3'd0, 1'b1, 16'h000D};
      vecs[16] = '{4'hA, 16'h0000, 3'd0, 1'b0, 16'h0000};
      vecs[17] = '{4'hD, 16'h0000, 3'd0, 1'b0, 16'h0000};
      vecs[18] = '{4'h6, 16'h0006, 3'd1, 1'b0, 16'h0000};
      vecs[19] = '{4'hE, 16'h0006, 3'd1, 1'b0, 16'h0000};
      vecs[20] = '{4'hF, 16'h0006, 3'd1, 1'b0, 16'h0000};
      vecs[21] = '{4'hC, 16'h0000, 3'd0, 1'b0, 16'h0000};
      vecs[22] = '{4'hB, 16'h0000, 3'd0, 1'b0, 16'h0000};
      vecs[23] = '{4'h8, 16'h0008, 3'd1, 1'b0, 16'h0000};
      vecs[24] = '{4'hB, 16'h0000, 3'd0, 1'b0, 16'h0000};
      vecs[25] = '{4'hA, 16'h0000, 3'd0, 1'b0, 16'h0000};
      vecs[26] = '{4'h3, 16'h0003, 3'd1, 1'b0, 16'h0000};
      vecs[27] = '{4'hA, 16'h0000, 3'd0, 1'b1, 16'h0003};
      rowtab[0] = 4'b1110; rowtab[1] = 4'b1101; rowtab[2] = 4'b1011; rowtab[3] = 4'b0111;

      // Reset state
      reset_button = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_row", {28'd0, row}, 32'hE);
      chk("rst_key_code", {28'd0, key_code}, 32'h0);
      chk("rst_key_valid", {31'd0, key_valid}, 32'h0);
      chk("rst_entry", {16'd0, entry_bcd}, 32'h0);
      chk("rst_digit_cnt", {29'd0, digit_cnt}, 32'h0);
      chk("rst_load_value", {16'd0, load_value}, 32'h0);
      chk("rst_load_valid", {31'd0, load_valid}, 32'h0);

      // Row scan after release, no keys
      @(negedge clk);
      reset_button = 1'b1;
      for (int k = 0; k < 48; k++) begin
         if (k > 0) @(negedge clk);
         if (k % 10 == 0 || k % 10 == 9)
            chk($sformatf("scan_row_c%0d", k), {28'd0, row}, {28'd0, rowtab[(k/10)%4]});
      end
      repeat (4 * FRAME) @(negedge clk);
      #1;
      chk("idle_kv_count", kv_cnt, 0);
      chk("idle_lv_count", lv_cnt, 0);
      chk("idle_entry", {16'd0, entry_bcd}, 32'h0);

      // Table-driven key presses
      for (int i = 0; i < 28; i++) begin
         kv0 = kv_cnt;
         lv0 = lv_cnt;
         press(vecs[i].key, HOLD);
         chk($sformatf("v%0d_kv_count", i), kv_cnt - kv0, 1);
         chk($sformatf("v%0d_key_code", i), {28'd0, kv_code}, {28'd0, vecs[i].key});
         chk($sformatf("v%0d_entry", i), {16'd0, entry_bcd}, {16'd0, vecs[i].exp_bcd});
         chk($sformatf("v%0d_digit_cnt", i), {29'd0, digit_cnt}, {29'd0, vecs[i].exp_cnt});
         chk($sformatf("v%0d_lv_count", i), lv_cnt - lv0, {31'd0, vecs[i].exp_load});
         if (vecs[i].exp_load) begin
            chk($sformatf("v%0d_load_value", i), {16'd0, lv_val}, {16'd0, vecs[i].exp_val});
            chk($sformatf("v%0d_load_latency", i), lv_lat, 5);
            chk($sformatf("v%0d_load_hold", i), {16'd0, load_value}, {16'd0, vecs[i].exp_val});
         end
      end

      // Contact bounce on '5', then a solid press
      kv0 = kv_cnt;
      for (int i = 0; i < 3; i++) begin
         pressed = '0;
         pressed[key_index(4'h5)] = 1'b1;
         repeat (FRAME) @(negedge clk);
         pressed = '0;
         repeat (FRAME) @(negedge clk);
      end
      press(4'h5, HOLD);
      chk("bounce_kv_count", kv_cnt - kv0, 1);
      chk("bounce_key_code", {28'd0, kv_code}, 32'h5);
      chk("bounce_entry", {16'd0, entry_bcd}, 32'h0005);
      press(4'hC, HOLD);
      chk("bounce_clear", {16'd0, entry_bcd}, 32'h0);

      // Two keys together are rejected
      kv0 = kv_cnt;
      @(negedge clk);
      pressed = '0;
      pressed[key_index(4'h1)] = 1'b1;
      pressed[key_index(4'h5)] = 1'b1;
      repeat (8 * FRAME) @(negedge clk);
      pressed = '0;
      repeat (REL * FRAME) @(negedge clk);
      #1;
      chk("ghost_kv_count", kv_cnt - kv0, 0);

      // Reset in the middle of a conversion
      press(4'h1, HOLD);
      press(4'h2, HOLD);
      chk("abort_entry", {16'd0, entry_bcd}, 32'h0012);
      lv0 = lv_cnt;
      kv0 = kv_cnt;
      guard = 0;
      @(negedge clk);
      pressed = '0;
      pressed[key_index(4'hA)] = 1'b1;
      while (kv_cnt == kv0 && guard < 20 * FRAME) begin
         @(negedge clk);
         #1;
         guard++;
      end
      chk("abort_enter_seen", {31'd0, kv_cnt != kv0}, 32'h1);
      pressed = '0;
      @(posedge clk);
      @(posedge clk);
      #2;
      reset_button = 1'b0;
      #1;
      chk("abort_load_value", {16'd0, load_value}, 32'h0);
      chk("abort_load_valid", {31'd0, load_valid}, 32'h0);
      chk("abort_entry_clr", {16'd0, entry_bcd}, 32'h0);
      chk("abort_digit_cnt", {29'd0, digit_cnt}, 32'h0);
      chk("abort_row", {28'd0, row}, 32'hE);
      repeat (5) @(negedge clk);
      reset_button = 1'b1;
      repeat (12 * FRAME) @(negedge clk);
      #1;
      chk("abort_no_load", lv_cnt - lv0, 0);
      chk("abort_load_value_after", {16'd0, load_value}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
